// File: rtl/block_uart_serializer.sv
// Feeds a wide data block, one byte at a time, into a byte-level UART transmitter.
// Follows the tx_start / tx_busy handshake and pulses done when the last frame ends.
module block_uart_serializer #(
    parameter int NUM_BYTES  = 64,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int GAP_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               blk_valid,
    input  logic [NUM_BYTES*8-1:0]             blk_data,
    output logic                               blk_ready,
    output logic                               tx_start,
    output logic [7:0]                         tx_data,
    input  logic                               tx_busy,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_BYTES+1)-1:0]     byte_idx
);

    // state     | meaning
    // IDLE      | blk_ready high, waiting for a block handshake
    // LOAD      | present current byte on tx_data, wait for transmitter idle
    // START     | tx_start high for this one cycle
    // WAIT_ACK  | wait for the transmitter to raise tx_busy
    // WAIT_DONE | wait for tx_busy to fall (frame end), then advance
    // GAP       | inter-byte idle time, down-counted
    // FINISH    | done pulse, release busy, return to IDLE

    localparam int W     = NUM_BYTES * 8;
    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic              blk_ready_q, blk_ready_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cur_byte;

    // The byte to send always sits at the shift register end selected by MSB_FIRST.
    assign cur_byte = MSB_FIRST ? shreg_q[W-1 -: 8] : shreg_q[7:0];

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        blk_ready_d = blk_ready_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                blk_ready_d = 1'b1;
                if (blk_valid && blk_ready_q) begin
                    shreg_d     = blk_data;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    blk_ready_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = cur_byte;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx_busy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end else if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 16'd0) state_d = S_LOAD;
                else gap_cnt_d = gap_cnt_q - 16'd1;
            end
            S_FINISH: begin
                busy_d      = 1'b0;
                idx_d       = '0;
                blk_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= 16'd0;
            blk_ready_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            blk_ready_q <= blk_ready_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign byte_idx  = idx_q;

endmodule

// File: doc/block_uart_serializer.md
Name: block_uart_serializer

Overview:
- Upstream feeder for the byte-level UART transmitter.
- Accepts one wide data block, e.g. a 64-byte ChaCha20 keystream or ciphertext block, over a valid/ready handshake.
- Sends it one byte at a time on the transmitter's tx_start / tx_data / tx_busy interface, in a fixed byte order.
- Signals completion with a one-cycle done pulse, then accepts the next block.

Parameters:
- NUM_BYTES, 64, number of bytes per block; legal range 1..256.
- MSB_FIRST, 0, 0 = byte 0 is blk_data[7:0] and is sent first; 1 = blk_data[NUM_BYTES*8-1 -: 8] is sent first.
- GAP_CYCLES, 0, idle clocks inserted after tx_busy falls and before the next tx_start; range 0..65535.

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  reset, asynchronous, active-low
- blk_valid  input  1  upstream block available
- blk_data  input  NUM_BYTES*8  block payload; sampled only on handshake
- blk_ready  output  1  block can be accepted
- tx_start  output  1  one-cycle request to the byte transmitter
- tx_data  output  8  byte to transmit; stable from tx_start until tx_busy falls
- tx_busy  input  1  transmitter busy status
- busy  output  1  block in progress
- done  output  1  one-cycle pulse after the last byte's tx_busy falls
- byte_idx  output  $clog2(NUM_BYTES+1)  index of the byte currently in flight

Behaviour:
- Reset (async assert, sync release), all outputs:
  - blk_ready=0, tx_start=0, tx_data=8'h00, busy=0, done=0, byte_idx=0.
  - State=IDLE; shift register cleared.
  - blk_ready goes to 1 on the first clock after release.
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, GAP, FINISH.
- IDLE:
  - blk_ready=1.
  - Handshake completes when blk_valid && blk_ready at a clock edge.
  - On handshake: capture blk_data into an internal shift register, byte_idx<=0, busy<=1, blk_ready<=0, go to LOAD.
- LOAD:
  - tx_data <= current byte, selected by MSB_FIRST.
  - If tx_busy=0, go to START; otherwise stay in LOAD, waiting for a foreign transfer to finish.
- START:
  - Assert tx_start for exactly one cycle, then go to WAIT_ACK.
  - tx_start is never asserted while tx_busy=1.
- WAIT_ACK:
  - Wait for tx_busy=1. The transmitter raises busy 2 clocks after tx_start.
  - No timeout; tx_start is not re-issued.
- WAIT_DONE:
  - Wait for tx_busy=0, which marks frame end.
  - Then shift the register by one byte and increment byte_idx.
  - If byte_idx was NUM_BYTES-1, go to FINISH.
  - Otherwise go to GAP if GAP_CYCLES>0, else to LOAD.
- GAP: count GAP_CYCLES clocks, then go to LOAD.
- FINISH: done=1 for one cycle, busy<=0, byte_idx<=0, go to IDLE.
- blk_ready stays 0 from handshake until the cycle after done.
- Back-to-back blocks: minimum one IDLE cycle between blocks; no bubble-free overlap.
- Minimum per-byte overhead is 4 clocks beyond the transmitter frame: LOAD, START, 2-cycle ack latency.
- tx_data holds its value through WAIT_ACK and WAIT_DONE; it changes only in LOAD.
- blk_data changes while busy=1 are ignored.
- Reset mid-block: abort immediately; tx_start drops asynchronously.
  - A transmitter frame already started completes on its own; this block does not track it.
  - After reset, if tx_busy=1, the next block waits in LOAD until it clears.
- NUM_BYTES=1: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, FINISH; done follows the single byte.

Test Plan:
- Single block, MSB_FIRST=0, NUM_BYTES=4, blk_data=32'hA1B2C3D4:
  - Bytes D4, C3, B2, A1 are sent in order.
  - Exactly 4 tx_start pulses, each 1 cycle wide.
  - done pulses once, 1 cycle after the 4th tx_busy fall.
  - blk_ready returns to 1 the cycle after done.
- MSB_FIRST=1, same data: byte order A1, B2, C3, D4; UART line decode at 115200 matches.
- tx_busy held 1 by the bench at block accept: stays in LOAD with no tx_start; release tx_busy, and tx_start follows within 2 clocks.
- GAP_CYCLES=10, NUM_BYTES=2: exactly 10 idle clocks between the first tx_busy fall and the second LOAD; byte_idx goes 0, 1, 0.
- Reset asserted during WAIT_DONE of byte 2 of 64:
  - Outputs return to reset values immediately.
  - The next block (all 8'h5A) sends all 64 bytes starting from byte 0, with no stale data.
- blk_valid held high with changing blk_data during a transfer: only the block sampled at handshake is sent; a second handshake occurs only after done.
